// File: rtl/alu_pipe.sv
// alu_pipe
// Two-stage pipelined dual-bank bitwise ALU with valid/ready handshakes and
// a sticky, counting interrupt.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   global_enable       1 = accept new operations; pipeline always drains
//   enable_a/enable_b   bank select at accept time (A has priority)
//   op_a/op_b           2-bit opcodes for bank A / bank B
//   in_a, in_b          operands
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   out/out_valid       registered result and its valid flag
//   out_ready           consumer accepts out
//   match_val/match_en  interrupt on result == match_val
//   zero_en             interrupt on result == 0
//   irq_clear           clears irq and irq_count
//   irq/irq_count       sticky interrupt and saturating event counter
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             global_enable,
    input  logic             enable_a,
    input  logic             enable_b,
    input  logic [1:0]       op_a,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] match_val,
    input  logic             match_en,
    input  logic             zero_en,
    input  logic             irq_clear,
    output logic             irq,
    output logic [CNT_W-1:0] irq_count
);

    logic             r_s1Valid;
    logic             r_s1BankB;
    logic [1:0]       r_s1Op;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    logic [WIDTH-1:0] r_out;
    logic             r_outValid;
    logic             r_irq;
    logic [CNT_W-1:0] r_irqCount;

    logic             w_adv2;
    logic             w_inReady;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_event;

    // Stage 2 may load whenever the output register is empty or being consumed.
    assign w_adv2    = !r_outValid || out_ready;
    assign w_inReady = global_enable && (!r_s1Valid || w_adv2);
    assign w_accept  = in_valid && w_inReady;

    // Bitwise result of the operation held in stage 1.
    always_comb begin
        w_result = '0;
        if (!r_s1BankB) begin
            case (r_s1Op)
                2'b00:   w_result = r_s1A & r_s1B;
                2'b01:   w_result = ~r_s1A & ~r_s1B;
                2'b10:   w_result = r_s1A | r_s1B;
                default: w_result = r_s1A ^ r_s1B;
            endcase
        end else begin
            case (r_s1Op)
                2'b00:   w_result = ~(r_s1A ^ r_s1B);
                2'b01:   w_result = r_s1A & r_s1B;
                2'b10:   w_result = ~(r_s1A | r_s1B);
                default: w_result = r_s1A | r_s1B;
            endcase
        end
    end

    // A single event even when both the match and zero conditions hold.
    assign w_event = w_adv2 && r_s1Valid &&
                     ((match_en && (w_result == match_val)) ||
                      (zero_en && (w_result == '0)));

    // Stage 1: capture an accepted transaction. A transaction with neither
    // bank enabled is consumed but leaves the stage empty. When intake is
    // blocked only by global_enable, the stage still empties into stage 2 so
    // the pipeline drains instead of replaying its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1BankB <= 1'b0;
            r_s1Op    <= 2'b00;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else if (w_inReady) begin
            r_s1Valid <= w_accept && (enable_a || enable_b);
            r_s1BankB <= !enable_a;
            r_s1Op    <= enable_a ? op_a : op_b;
            r_s1A     <= in_a;
            r_s1B     <= in_b;
        end else if (w_adv2) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_outValid <= 1'b0;
        end else if (w_adv2) begin
            r_out      <= w_result;
            r_outValid <= r_s1Valid;
        end
    end

    // Sticky interrupt and saturating counter; a same-cycle event beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq      <= 1'b0;
            r_irqCount <= '0;
        end else if (irq_clear) begin
            r_irq      <= w_event;
            r_irqCount <= w_event ? CNT_W'(1) : '0;
        end else if (w_event) begin
            r_irq <= 1'b1;
            if (r_irqCount != '1) begin
                r_irqCount <= r_irqCount + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out       = r_out;
    assign out_valid = r_outValid;
    assign irq       = r_irq;
    assign irq_count = r_irqCount;

endmodule
